// File: rtl/pipe_intr_pkg.sv
// rtl/pipe_intr_pkg.sv - shared constants, types and helpers for the pipeline interrupt sequencer
package pipe_intr_pkg;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam logic [4:0] C0_COUNT   = 5'd9;
    localparam logic [4:0] C0_COMPARE = 5'd11;
    localparam logic [4:0] C0_STATUS  = 5'd12;
    localparam logic [4:0] C0_CAUSE   = 5'd13;
    localparam logic [4:0] C0_EPC     = 5'd14;

    localparam int SR_IE     = 0;
    localparam int SR_IM_EXT = 10;
    localparam int SR_IM_TMR = 11;
    localparam int CR_BD     = 31;
    localparam int CR_IP_EXT = 10;
    localparam int CR_IP_TMR = 11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ACK     = 2'd1,
        ST_WAITLOW = 2'd2
    } intr_state_t;

    // A delay-slot instruction restarts at its branch, one word earlier (wraps at 0).
    function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic bd);
        return bd ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/pipe_intr_ctrl_if.sv
// rtl/pipe_intr_ctrl_if.sv - external interrupt handshake and mtc0/mfc0 register bus
interface pipe_intr_ctrl_if;
    logic        intr;
    logic        inta;
    logic        c0_we;
    logic [4:0]  c0_waddr;
    logic [31:0] c0_wdata;
    logic [4:0]  c0_raddr;
    logic [31:0] c0_rdata;

    modport master (output intr, c0_we, c0_waddr, c0_wdata, c0_raddr,
                    input  inta, c0_rdata);
    modport slave  (input  intr, c0_we, c0_waddr, c0_wdata, c0_raddr,
                    output inta, c0_rdata);
endinterface

// File: rtl/pipe_c0_regs.sv
// rtl/pipe_c0_regs.sv - CP0 Status/Cause/EPC storage, mfc0 read mux; timer under PIPE_INTR_TIMER_EN
module pipe_c0_regs
    import pipe_intr_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        intr,
    input  logic        c0_we,
    input  logic [4:0]  c0_waddr,
    input  logic [31:0] c0_wdata,
    input  logic [4:0]  c0_raddr,
    output logic [31:0] c0_rdata,
    input  logic        exc_take,
    input  logic [4:0]  exc_code,
    input  logic        exc_bd,
    input  logic [31:0] exc_epc,
    input  logic        eret_take,
    output logic        ie,
    output logic        im_ext,
    output logic        im_tmr,
    output logic        ip_tmr,
    output logic [31:0] epc
);

    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic        bd_q;
    logic [4:0]  exccode_q;
    logic [31:0] cause_v;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;

    assign wr_status = c0_we && (c0_waddr == C0_STATUS);
    assign wr_cause  = c0_we && (c0_waddr == C0_CAUSE);
    assign wr_epc    = c0_we && (c0_waddr == C0_EPC);

    // Sequencer updates are written last so they win over a same-cycle mtc0 to the same field.
    always_ff @(posedge clk) begin
        if (clr) begin
            status_q  <= '0;
            epc_q     <= '0;
            bd_q      <= 1'b0;
            exccode_q <= '0;
        end else begin
            if (wr_status)
                status_q <= c0_wdata;
            if (exc_take)
                status_q[SR_IE] <= 1'b0;
            else if (eret_take)
                status_q[SR_IE] <= 1'b1;
            if (exc_take) begin
                epc_q     <= exc_epc;
                bd_q      <= exc_bd;
                exccode_q <= exc_code;
            end else begin
                if (wr_epc)
                    epc_q <= c0_wdata;
                if (wr_cause) begin
                    bd_q      <= c0_wdata[CR_BD];
                    exccode_q <= c0_wdata[6:2];
                end
            end
        end
    end

`ifdef PIPE_INTR_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        ip_tmr_q;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = c0_we && (c0_waddr == C0_COUNT);
    assign wr_compare = c0_we && (c0_waddr == C0_COMPARE);

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q   <= '0;
            compare_q <= '0;
            ip_tmr_q  <= 1'b0;
        end else begin
            count_q <= wr_count ? c0_wdata : count_q + 32'd1;
            if (wr_compare)
                compare_q <= c0_wdata;
            if (wr_compare)
                ip_tmr_q <= 1'b0;
            else if (count_q == compare_q)
                ip_tmr_q <= 1'b1;
        end
    end

    assign ip_tmr = ip_tmr_q;
`else
    assign ip_tmr = 1'b0;
`endif

    always_comb begin
        cause_v            = '0;
        cause_v[CR_BD]     = bd_q;
        cause_v[6:2]       = exccode_q;
        cause_v[CR_IP_EXT] = intr;
        cause_v[CR_IP_TMR] = ip_tmr;
    end

    always_comb begin
        c0_rdata = '0;
        case (c0_raddr)
            C0_STATUS:  c0_rdata = status_q;
            C0_CAUSE:   c0_rdata = cause_v;
            C0_EPC:     c0_rdata = epc_q;
`ifdef PIPE_INTR_TIMER_EN
            C0_COUNT:   c0_rdata = count_q;
            C0_COMPARE: c0_rdata = compare_q;
`endif
            default:    c0_rdata = '0;
        endcase
    end

    assign ie     = status_q[SR_IE];
    assign im_ext = status_q[SR_IM_EXT];
    assign im_tmr = status_q[SR_IM_TMR];
    assign epc    = epc_q;

endmodule

// File: rtl/pipe_intr_ctrl.sv
// rtl/pipe_intr_ctrl.sv - exception priority, PC redirect, cancels and inta FSM (timer source via PIPE_INTR_TIMER_EN)
module pipe_intr_ctrl
    import pipe_intr_pkg::*;
#(
    parameter logic [31:0] VECTOR = 32'h0000_0008
) (
    input  logic              clk,
    input  logic              clr,
    pipe_intr_ctrl_if.slave   bus,
    input  logic [31:0]       dpc,
    input  logic              id_valid,
    input  logic              id_bd,
    input  logic              nostall,
    input  logic              id_syscall,
    input  logic              id_unimpl,
    input  logic              id_eret,
    input  logic [31:0]       epc_exe,
    input  logic              exe_valid,
    input  logic              exe_bd,
    input  logic              exe_ov,
    output logic              pcsel,
    output logic [31:0]       newpc,
    output logic              cancel_id,
    output logic              cancel_exe
);

    intr_state_t state_q, state_nx;

    logic        ie, im_ext, im_tmr, ip_tmr;
    logic [31:0] epc;
    logic        id_ok, ext_req, tmr_req;
    logic        exc_take, eret_take, ext_take;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic        inta_v;

    pipe_c0_regs u_c0 (
        .clk       (clk),
        .clr       (clr),
        .intr      (bus.intr),
        .c0_we     (bus.c0_we),
        .c0_waddr  (bus.c0_waddr),
        .c0_wdata  (bus.c0_wdata),
        .c0_raddr  (bus.c0_raddr),
        .c0_rdata  (bus.c0_rdata),
        .exc_take  (exc_take),
        .exc_code  (exc_code),
        .exc_bd    (exc_bd),
        .exc_epc   (exc_epc),
        .eret_take (eret_take),
        .ie        (ie),
        .im_ext    (im_ext),
        .im_tmr    (im_tmr),
        .ip_tmr    (ip_tmr),
        .epc       (epc)
    );

    // Asynchronous sources are only taken on a real, advancing ID instruction so EPC is exact.
    assign id_ok   = id_valid && nostall;
    assign ext_req = bus.intr && ie && im_ext && id_ok && (state_q == ST_RUN);
    assign tmr_req = ip_tmr && ie && im_tmr && id_ok;

    always_comb begin
        exc_take   = 1'b0;
        eret_take  = 1'b0;
        ext_take   = 1'b0;
        exc_code   = EXC_INT;
        exc_bd     = id_bd;
        exc_epc    = restart_pc(dpc, id_bd);
        cancel_id  = 1'b0;
        cancel_exe = 1'b0;
        if (exe_ov && exe_valid) begin
            exc_take   = 1'b1;
            exc_code   = EXC_OV;
            exc_bd     = exe_bd;
            exc_epc    = restart_pc(epc_exe, exe_bd);
            cancel_exe = 1'b1;
            cancel_id  = 1'b1;
        end else if (id_ok && id_unimpl) begin
            exc_take  = 1'b1;
            exc_code  = EXC_RI;
            cancel_id = 1'b1;
        end else if (id_ok && id_syscall) begin
            exc_take  = 1'b1;
            exc_code  = EXC_SYS;
            cancel_id = 1'b1;
        end else if (id_ok && id_eret) begin
            eret_take = 1'b1;
        end else if (ext_req) begin
            exc_take  = 1'b1;
            ext_take  = 1'b1;
            cancel_id = 1'b1;
        end else if (tmr_req) begin
            exc_take  = 1'b1;
            cancel_id = 1'b1;
        end
    end

    assign pcsel = exc_take || eret_take;
    assign newpc = exc_take ? VECTOR : (eret_take ? epc : 32'h0);

    always_ff @(posedge clk) begin
        if (clr)
            state_q <= ST_RUN;
        else
            state_q <= state_nx;
    end

    // WAITLOW blocks retaking a level request that the device has not yet dropped.
    always_comb begin
        state_nx = state_q;
        inta_v   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ext_take)
                    state_nx = ST_ACK;
            end
            ST_ACK: begin
                inta_v   = 1'b1;
                state_nx = ST_WAITLOW;
            end
            ST_WAITLOW: begin
                if (!bus.intr)
                    state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    assign bus.inta = inta_v;

endmodule

// File: tb/tb_pipe_intr_ctrl.sv
// tb/tb_pipe_intr_ctrl.sv - directed self-checking bench for pipe_intr_ctrl
module tb_pipe_intr_ctrl;
    import pipe_intr_pkg::*;

    logic        clk;
    logic        clr;
    logic [31:0] dpc;
    logic        id_valid, id_bd, nostall, id_syscall, id_unimpl, id_eret;
    logic [31:0] epc_exe;
    logic        exe_valid, exe_bd, exe_ov;
    logic        pcsel;
    logic [31:0] newpc;
    logic        cancel_id, cancel_exe;
    int          checks;
    int          errors;

    pipe_intr_ctrl_if bus();

    pipe_intr_ctrl #(.VECTOR(32'h0000_0008)) dut (
        .clk        (clk),
        .clr        (clr),
        .bus        (bus),
        .dpc        (dpc),
        .id_valid   (id_valid),
        .id_bd      (id_bd),
        .nostall    (nostall),
        .id_syscall (id_syscall),
        .id_unimpl  (id_unimpl),
        .id_eret    (id_eret),
        .epc_exe    (epc_exe),
        .exe_valid  (exe_valid),
        .exe_bd     (exe_bd),
        .exe_ov     (exe_ov),
        .pcsel      (pcsel),
        .newpc      (newpc),
        .cancel_id  (cancel_id),
        .cancel_exe (cancel_exe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        dpc = '0; id_valid = 0; id_bd = 0; nostall = 0;
        id_syscall = 0; id_unimpl = 0; id_eret = 0;
        epc_exe = '0; exe_valid = 0; exe_bd = 0; exe_ov = 0;
        bus.c0_we = 0; bus.c0_waddr = '0; bus.c0_wdata = '0; bus.c0_raddr = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.c0_we = 1; bus.c0_waddr = a; bus.c0_wdata = d;
        @(negedge clk);
        bus.c0_we = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.c0_raddr = a;
        #1;
        d = bus.c0_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        idle(); bus.intr = 0; clr = 1;
        @(posedge clk); @(posedge clk);
        @(negedge clk); clr = 0; #1;
        checks++; if ({pcsel, cancel_id, cancel_exe, bus.inta} !== 4'b0) begin errors++; $display("FAIL reset_outs got %b exp 0000", {pcsel, cancel_id, cancel_exe, bus.inta}); end
        checks++; if (newpc !== 32'h0) begin errors++; $display("FAIL reset_newpc got %h exp 0", newpc); end
        rd(C0_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", d); end
        rd(C0_CAUSE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp 0", d); end
        rd(C0_EPC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp 0", d); end
    endtask

    task automatic test_ext_intr();
        logic [31:0] d;
        mtc0(C0_STATUS, 32'h0000_0401);
        bus.intr = 1; dpc = 32'h40; id_valid = 1; nostall = 1; #1;
        checks++; if ({pcsel, cancel_id, cancel_exe} !== 3'b110) begin errors++; $display("FAIL ext_take got %b exp 110", {pcsel, cancel_id, cancel_exe}); end
        checks++; if (newpc !== 32'h8) begin errors++; $display("FAIL ext_newpc got %h exp 8", newpc); end
        @(negedge clk); #1;
        checks++; if (bus.inta !== 1'b1) begin errors++; $display("FAIL ext_inta_hi got %b exp 1", bus.inta); end
        checks++; if (pcsel !== 1'b0) begin errors++; $display("FAIL ext_ack_noretake got %b exp 0", pcsel); end
        rd(C0_EPC, d);
        checks++; if (d !== 32'h40) begin errors++; $display("FAIL ext_epc got %h exp 40", d); end
        rd(C0_CAUSE, d);
        checks++; if (d !== 32'h400) begin errors++; $display("FAIL ext_cause got %h exp 400", d); end
        rd(C0_STATUS, d);
        checks++; if (d !== 32'h400) begin errors++; $display("FAIL ext_status got %h exp 400", d); end
        @(negedge clk); #1;
        checks++; if (bus.inta !== 1'b0) begin errors++; $display("FAIL ext_inta_pulse got %b exp 0", bus.inta); end
        bus.c0_we = 1; bus.c0_waddr = C0_STATUS; bus.c0_wdata = 32'h401;
        @(negedge clk); bus.c0_we = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({pcsel, bus.inta} !== 2'b00) begin errors++; $display("FAIL ext_waitlow_%0d got %b exp 00", i, {pcsel, bus.inta}); end
            if (i < 2) @(negedge clk);
        end
        bus.intr = 0;
        @(negedge clk);
        bus.intr = 1; #1;
        checks++; if (pcsel !== 1'b1) begin errors++; $display("FAIL ext_retake_after_low got %b exp 1", pcsel); end
        @(negedge clk);
        bus.intr = 0; id_valid = 0; #1;
        checks++; if (bus.inta !== 1'b1) begin errors++; $display("FAIL ext_second_inta got %b exp 1", bus.inta); end
        @(negedge clk); @(negedge clk);
        idle();
    endtask

    task automatic test_ov_priority();
        logic [31:0] d;
        @(negedge clk);
        exe_ov = 1; exe_valid = 1; epc_exe = 32'h20; exe_bd = 1;
        id_valid = 1; nostall = 1; id_syscall = 1; dpc = 32'h44; #1;
        checks++; if ({pcsel, cancel_id, cancel_exe} !== 3'b111) begin errors++; $display("FAIL ov_outs got %b exp 111", {pcsel, cancel_id, cancel_exe}); end
        checks++; if (newpc !== 32'h8) begin errors++; $display("FAIL ov_newpc got %h exp 8", newpc); end
        @(negedge clk); idle();
        rd(C0_EPC, d);
        checks++; if (d !== 32'h1C) begin errors++; $display("FAIL ov_epc got %h exp 1c", d); end
        rd(C0_CAUSE, d);
        checks++; if (d !== 32'h8000_0030) begin errors++; $display("FAIL ov_cause got %h exp 80000030", d); end
    endtask

    task automatic test_stall_id();
        logic [31:0] d;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            id_valid = 1; id_syscall = 1; nostall = 0; dpc = 32'h80; #1;
            checks++; if ({pcsel, cancel_id} !== 2'b00) begin errors++; $display("FAIL stall_%0d got %b exp 00", i, {pcsel, cancel_id}); end
        end
        @(negedge clk);
        nostall = 1; bus.c0_we = 1; bus.c0_waddr = C0_EPC; bus.c0_wdata = 32'h999; #1;
        checks++; if ({pcsel, cancel_id, cancel_exe} !== 3'b110) begin errors++; $display("FAIL sys_outs got %b exp 110", {pcsel, cancel_id, cancel_exe}); end
        @(negedge clk); idle();
        rd(C0_EPC, d);
        checks++; if (d !== 32'h80) begin errors++; $display("FAIL sys_epc_wins got %h exp 80", d); end
        rd(C0_CAUSE, d);
        checks++; if (d !== 32'h20) begin errors++; $display("FAIL sys_cause got %h exp 20", d); end
        @(negedge clk);
        id_valid = 1; nostall = 1; id_unimpl = 1; id_syscall = 1; id_bd = 1; dpc = 32'h0; #1;
        checks++; if ({pcsel, cancel_id} !== 2'b11) begin errors++; $display("FAIL ri_outs got %b exp 11", {pcsel, cancel_id}); end
        @(negedge clk); idle();
        rd(C0_EPC, d);
        checks++; if (d !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ri_epc_wrap got %h exp fffffffc", d); end
        rd(C0_CAUSE, d);
        checks++; if (d !== 32'h8000_0028) begin errors++; $display("FAIL ri_cause got %h exp 80000028", d); end
    endtask

    task automatic test_eret();
        logic [31:0] d;
        mtc0(C0_EPC, 32'h100);
        id_valid = 1; nostall = 1; id_eret = 1;
        bus.c0_we = 1; bus.c0_waddr = C0_STATUS; bus.c0_wdata = 32'h800; #1;
        checks++; if ({pcsel, cancel_id, cancel_exe} !== 3'b100) begin errors++; $display("FAIL eret_outs got %b exp 100", {pcsel, cancel_id, cancel_exe}); end
        checks++; if (newpc !== 32'h100) begin errors++; $display("FAIL eret_newpc got %h exp 100", newpc); end
        rd(C0_STATUS, d);
        checks++; if (d !== 32'h400) begin errors++; $display("FAIL eret_nobypass got %h exp 400", d); end
        @(negedge clk); idle();
        rd(C0_STATUS, d);
        checks++; if (d !== 32'h801) begin errors++; $display("FAIL eret_status got %h exp 801", d); end
    endtask

    task automatic test_reset_waitlow();
        logic [31:0] d;
        mtc0(C0_STATUS, 32'h401);
        bus.intr = 1; id_valid = 1; nostall = 1; dpc = 32'h60; #1;
        checks++; if (pcsel !== 1'b1) begin errors++; $display("FAIL rw_take got %b exp 1", pcsel); end
        @(negedge clk); @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0; #1;
        checks++; if ({pcsel, bus.inta} !== 2'b00) begin errors++; $display("FAIL rw_after_clr got %b exp 00", {pcsel, bus.inta}); end
        rd(C0_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rw_status got %h exp 0", d); end
        rd(C0_EPC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rw_epc got %h exp 0", d); end
        rd(C0_CAUSE, d);
        checks++; if (d !== 32'h400) begin errors++; $display("FAIL rw_cause got %h exp 400", d); end
        bus.c0_we = 1; bus.c0_waddr = C0_STATUS; bus.c0_wdata = 32'h401;
        @(negedge clk);
        bus.c0_we = 0; #1;
        checks++; if (pcsel !== 1'b1) begin errors++; $display("FAIL rw_fsm_run got %b exp 1", pcsel); end
        @(negedge clk);
        bus.intr = 0; id_valid = 0; #1;
        checks++; if (bus.inta !== 1'b1) begin errors++; $display("FAIL rw_inta got %b exp 1", bus.inta); end
        @(negedge clk); @(negedge clk);
        idle();
    endtask

`ifdef PIPE_INTR_TIMER_EN
    task automatic test_timer();
        logic [31:0] d;
        logic [31:0] c;
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        mtc0(C0_COUNT, 32'h0);
        mtc0(C0_COMPARE, 32'h5);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk);
            rd(C0_COUNT, c);
            rd(C0_CAUSE, d);
            checks++; if (c !== 32'd2 + 32'(k)) begin errors++; $display("FAIL tmr_count_%0d got %h exp %h", k, c, 32'd2 + 32'(k)); end
            checks++; if (d[CR_IP_TMR] !== (k == 4)) begin errors++; $display("FAIL tmr_ip_%0d got %b exp %b", k, d[CR_IP_TMR], (k == 4)); end
        end
        mtc0(C0_STATUS, 32'h801);
        id_valid = 1; nostall = 1; dpc = 32'h200; #1;
        checks++; if ({pcsel, cancel_id} !== 2'b11) begin errors++; $display("FAIL tmr_take got %b exp 11", {pcsel, cancel_id}); end
        @(negedge clk); idle(); #1;
        checks++; if (bus.inta !== 1'b0) begin errors++; $display("FAIL tmr_no_inta got %b exp 0", bus.inta); end
        rd(C0_CAUSE, d);
        checks++; if (d !== 32'h800) begin errors++; $display("FAIL tmr_cause got %h exp 800", d); end
        rd(C0_EPC, d);
        checks++; if (d !== 32'h200) begin errors++; $display("FAIL tmr_epc got %h exp 200", d); end
        mtc0(C0_COMPARE, 32'd100);
        rd(C0_CAUSE, d);
        checks++; if (d[CR_IP_TMR] !== 1'b0) begin errors++; $display("FAIL tmr_clear got %b exp 0", d[CR_IP_TMR]); end
    endtask
`else
    task automatic test_no_timer();
        logic [31:0] d;
        mtc0(C0_COUNT, 32'h55);
        mtc0(C0_COMPARE, 32'h66);
        mtc0(5'd5, 32'hDEAD);
        rd(C0_COUNT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL nt_count got %h exp 0", d); end
        rd(C0_COMPARE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL nt_compare got %h exp 0", d); end
        rd(5'd5, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL nt_unmapped got %h exp 0", d); end
        rd(C0_CAUSE, d);
        checks++; if (d[CR_IP_TMR] !== 1'b0) begin errors++; $display("FAIL nt_ip_tmr got %b exp 0", d[CR_IP_TMR]); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        clr = 1;
        bus.intr = 0;
        idle();
        test_reset();
        test_ext_intr();
        test_ov_priority();
        test_stall_id();
        test_eret();
        test_reset_waitlow();
`ifdef PIPE_INTR_TIMER_EN
        test_timer();
`else
        test_no_timer();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
